// File: rtl/nibble_serial_tx_pkg.sv
// Shared definitions for the nibble serial transmitter: FSM state encoding,
// default timing parameters and small helper functions.
package nibble_serial_tx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 4;
  localparam int DEFAULT_STOP_BITS    = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Baud counter needs at least one bit even when each bit lasts one cycle.
  function automatic int baud_cnt_width(input int clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

  function automatic logic even_parity(input logic [3:0] nib);
    return ^nib;
  endfunction

endpackage

// File: rtl/nibble_serial_tx_if.sv
// Load/data request and serial line/status bundle of the nibble transmitter.
interface nibble_serial_tx_if;

  logic       load;
  logic [3:0] data;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output load,
    output data,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  data,
    output tx,
    output busy,
    output done
  );

endinterface

// File: rtl/nibble_serial_tx_bit_timer.sv
// Baud timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit
// period with tick. clear holds the count at zero.
module nibble_serial_tx_bit_timer
  import nibble_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/nibble_serial_tx.sv
// Nibble serial transmitter: start bit, 4 data bits LSB first, optional even
// parity bit (macro NIBBLE_TX_PARITY_EN), then STOP_BITS stop bits.
module nibble_serial_tx
  import nibble_serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = DEFAULT_STOP_BITS
) (
  input  logic               clk,
  input  logic               reset,
  nibble_serial_tx_if.slave  bus
);

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] shift_q;
  logic [3:0] shift_d;
  logic [1:0] bit_cnt_q;
  logic [1:0] bit_cnt_d;
  logic       stop_cnt_q;
  logic       stop_cnt_d;
  logic       tx_q;
  logic       tx_d;
  logic       busy_q;
  logic       busy_d;
  logic       done_q;
  logic       done_d;
`ifdef NIBBLE_TX_PARITY_EN
  logic       parity_q;
  logic       parity_d;
`endif

  logic tick;
  logic timer_clear;

  // Timer is held at zero while idle so a frame always starts on a fresh bit period.
  assign timer_clear = (state_q == ST_IDLE);

  nibble_serial_tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef NIBBLE_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
`ifdef NIBBLE_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!bus.load) begin
          state_d    = ST_START;
          shift_d    = bus.data;
          bit_cnt_d  = 2'd0;
          stop_cnt_d = 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
          parity_d   = even_parity(bus.data);
`endif
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = {1'b0, shift_q[3:1]};
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (bit_cnt_q == 2'd3) begin
`ifdef NIBBLE_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef NIBBLE_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d    = ST_IDLE;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered line changes on the same edge as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && (state_d == ST_IDLE);
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef NIBBLE_TX_PARITY_EN
      ST_PARITY: tx_d = parity_q;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_nibble_serial_tx.sv
// Directed bench for nibble_serial_tx: one instance at 4 clocks/bit with 1 stop
// bit, one at 1 clock/bit with 2 stop bits; honours NIBBLE_TX_PARITY_EN.
module tb_nibble_serial_tx;

  localparam int CLKS_A  = 4;
  localparam int STOPS_A = 1;
  localparam int CLKS_B  = 1;
  localparam int STOPS_B = 2;
`ifdef NIBBLE_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   check_count = 0;
  int   pass_count  = 0;

  nibble_serial_tx_if bus_a ();
  nibble_serial_tx_if bus_b ();

  nibble_serial_tx #(
    .CLKS_PER_BIT (CLKS_A),
    .STOP_BITS    (STOPS_A)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  nibble_serial_tx #(
    .CLKS_PER_BIT (CLKS_B),
    .STOP_BITS    (STOPS_B)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  function automatic int clksOf(input int which);
    return (which == 0) ? CLKS_A : CLKS_B;
  endfunction

  function automatic int stopsOf(input int which);
    return (which == 0) ? STOPS_A : STOPS_B;
  endfunction

  function automatic int frameLen(input int which);
    return (5 + PAR_BITS + stopsOf(which)) * clksOf(which);
  endfunction

  // Expected line level k cycles into a frame: start, d0..d3, [parity], stops.
  function automatic logic expTx(input int k, input int clks, input logic [3:0] d);
    int idx;
    idx = k / clks;
    case (idx)
      0:       return 1'b0;
      1:       return d[0];
      2:       return d[1];
      3:       return d[2];
      4:       return d[3];
      default: return (PAR_BITS == 1 && idx == 5) ? ^d : 1'b1;
    endcase
  endfunction

  function automatic logic [2:0] getObs(input int which);
    if (which == 0) begin
      return {bus_a.tx, bus_a.busy, bus_a.done};
    end
    return {bus_b.tx, bus_b.busy, bus_b.done};
  endfunction

  task automatic checkOutput(input string tag, input logic [2:0] got, input logic [2:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: tx/busy/done got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int which, input logic ld, input logic [3:0] d);
    if (which == 0) begin
      bus_a.load = ld;
      bus_a.data = d;
    end else begin
      bus_b.load = ld;
      bus_b.data = d;
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle 0 of the new frame.
  task automatic startFrame(input int which, input logic [3:0] d, input logic keep_low);
    applyStimulus(which, 1'b0, d);
    @(negedge clk);
    if (!keep_low) begin
      applyStimulus(which, 1'b1, 4'h0);
    end
  endtask

  // Checks every frame cycle; ends at the negedge of the done cycle.
  task automatic checkFrameBody(input int which, input logic [3:0] d, input int inject_at,
                                input string name);
    int len;
    len = frameLen(which);
    for (int k = 0; k < len; k++) begin
      checkOutput($sformatf("%s[%0d]", name, k), getObs(which),
                  {expTx(k, clksOf(which), d), 2'b10});
      if (k == inject_at) begin
        applyStimulus(which, 1'b0, 4'hF);
      end else if (inject_at >= 0 && k == inject_at + 1) begin
        applyStimulus(which, 1'b1, 4'h0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    applyStimulus(0, 1'b1, 4'h0);
    applyStimulus(1, 1'b1, 4'h0);
    #2 reset = 1'b1;
    #2;
    checkOutput("a_reset", getObs(0), 3'b100);
    checkOutput("b_reset", getObs(1), 3'b100);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput($sformatf("a_idle[%0d]", i), getObs(0), 3'b100);
      checkOutput($sformatf("b_idle[%0d]", i), getObs(1), 3'b100);
    end

    $display("[TB] single frame 1010 at 4 clocks/bit");
    startFrame(0, 4'b1010, 1'b0);
    checkFrameBody(0, 4'b1010, -1, "a_frame");
    checkOutput("a_done", getObs(0), 3'b101);
    @(negedge clk);
    checkOutput("a_done_once", getObs(0), 3'b100);

    $display("[TB] load pulse while busy is ignored");
    startFrame(0, 4'b1010, 1'b0);
    checkFrameBody(0, 4'b1010, 10, "a_ignore");
    checkOutput("a_ignore_done", getObs(0), 3'b101);
    @(negedge clk);
    checkOutput("a_ignore_idle", getObs(0), 3'b100);

    $display("[TB] back-to-back frames with load held low");
    startFrame(0, 4'h3, 1'b1);
    checkFrameBody(0, 4'h3, -1, "a_b2b1");
    checkOutput("a_b2b1_done", getObs(0), 3'b101);
    applyStimulus(0, 1'b0, 4'hC);
    @(negedge clk);
    checkFrameBody(0, 4'hC, -1, "a_b2b2");
    checkOutput("a_b2b2_done", getObs(0), 3'b101);
    applyStimulus(0, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("a_b2b_idle", getObs(0), 3'b100);

    $display("[TB] asynchronous reset mid-frame");
    startFrame(0, 4'b1010, 1'b0);
    repeat (9) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checkOutput("a_async_reset", getObs(0), 3'b100);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("a_post_reset[%0d]", i), getObs(0), 3'b100);
    end
    startFrame(0, 4'b0110, 1'b0);
    checkFrameBody(0, 4'b0110, -1, "a_clean");
    checkOutput("a_clean_done", getObs(0), 3'b101);
    @(negedge clk);

    $display("[TB] 1 clock/bit, 2 stop bits");
    startFrame(1, 4'b0111, 1'b0);
    checkFrameBody(1, 4'b0111, -1, "b_frame");
    checkOutput("b_done", getObs(1), 3'b101);
    @(negedge clk);
    checkOutput("b_done_once", getObs(1), 3'b100);

    startFrame(1, 4'h5, 1'b1);
    checkFrameBody(1, 4'h5, -1, "b_b2b1");
    checkOutput("b_b2b1_done", getObs(1), 3'b101);
    applyStimulus(1, 1'b0, 4'hA);
    @(negedge clk);
    checkFrameBody(1, 4'hA, -1, "b_b2b2");
    checkOutput("b_b2b2_done", getObs(1), 3'b101);
    applyStimulus(1, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("b_b2b_idle", getObs(1), 3'b100);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
